// File: rtl/micro_pkg.sv
// ============================================================================
// Module      : micro_pkg
// Description : Microword format, sequencing codes, microcode addresses and
//               ROM image for the multicycle ARM controller micro-sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package micro_pkg;

    localparam int c_UADDR_W = 4;

    typedef logic [c_UADDR_W-1:0] uaddr_t;

    typedef enum logic [1:0] {
        SEQ_JUMP  = 2'b00,
        SEQ_DISP1 = 2'b01,
        SEQ_DISP2 = 2'b10,
        SEQ_HOLD  = 2'b11
    } seq_t;

    typedef struct packed {
        logic       irwrite;
        logic       adrsrc;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] resultsrc;
        logic       nextpc;
        logic       regw;
        logic       memw;
        logic       branch;
        logic       aluop;
        logic       memacc;
        seq_t       seq;
        uaddr_t     nxt;
    } microword_t;

    localparam uaddr_t c_FETCH    = 4'd0;
    localparam uaddr_t c_DECODE   = 4'd1;
    localparam uaddr_t c_MEMADR   = 4'd2;
    localparam uaddr_t c_MEMREAD  = 4'd3;
    localparam uaddr_t c_MEMWB    = 4'd4;
    localparam uaddr_t c_MEMWRITE = 4'd5;
    localparam uaddr_t c_EXECR    = 4'd6;
    localparam uaddr_t c_EXECI    = 4'd7;
    localparam uaddr_t c_ALUWB    = 4'd8;
    localparam uaddr_t c_BRANCH   = 4'd9;
    localparam uaddr_t c_TRAP     = 4'd10;

    function automatic microword_t f_uword(
        input logic       irw,  input logic       adr,  input logic srca,
        input logic [1:0] srcb, input logic [1:0] rsrc, input logic npc,
        input logic       regw, input logic       memw, input logic br,
        input logic       aop,  input logic       macc, input seq_t seq,
        input uaddr_t     nxt
    );
        return '{irwrite: irw, adrsrc: adr, alusrca: srca, alusrcb: srcb,
                 resultsrc: rsrc, nextpc: npc, regw: regw, memw: memw,
                 branch: br, aluop: aop, memacc: macc, seq: seq, nxt: nxt};
    endfunction

    localparam microword_t c_TRAP_WORD =
        f_uword(1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, SEQ_HOLD, c_TRAP);

    //                  irw   adr   srcA  srcB   rsrc   npc   regw  memw  br    aop   macc  seq        nxt
    localparam microword_t c_ROM [0:(2**c_UADDR_W)-1] = '{
        f_uword(1'b1, 1'b0, 1'b1, 2'b10, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, SEQ_JUMP,  c_DECODE),
        f_uword(1'b0, 1'b0, 1'b1, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, SEQ_DISP1, c_FETCH),
        f_uword(1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, SEQ_DISP2, c_FETCH),
        f_uword(1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, SEQ_JUMP,  c_MEMWB),
        f_uword(1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, SEQ_JUMP,  c_FETCH),
        f_uword(1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, SEQ_JUMP,  c_FETCH),
        f_uword(1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, SEQ_JUMP,  c_ALUWB),
        f_uword(1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, SEQ_JUMP,  c_ALUWB),
        f_uword(1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, SEQ_JUMP,  c_FETCH),
        f_uword(1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, SEQ_JUMP,  c_FETCH),
        c_TRAP_WORD, c_TRAP_WORD, c_TRAP_WORD, c_TRAP_WORD, c_TRAP_WORD, c_TRAP_WORD
    };

    // Instruction-class dispatch; only Funct[5] and Funct[0] matter here.
    function automatic uaddr_t f_disp1(input logic [1:0] op, input logic funct5);
        case (op)
            2'b00:   return funct5 ? c_EXECI : c_EXECR;
            2'b01:   return c_MEMADR;
            2'b10:   return c_BRANCH;
            default: return c_TRAP;
        endcase
    endfunction

    function automatic uaddr_t f_disp2(input logic funct0);
        return funct0 ? c_MEMREAD : c_MEMWRITE;
    endfunction

endpackage

`default_nettype wire

// File: rtl/micro_rom.sv
// ============================================================================
// Module      : micro_rom
// Description : Combinational microcode lookup; addresses beyond the image
//               return the TRAP word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module micro_rom
    import micro_pkg::*;
#(
    parameter int UADDR_W = c_UADDR_W
) (
    input  logic [UADDR_W-1:0] addr,
    output microword_t         word
);

    generate
        if (UADDR_W == c_UADDR_W) begin : g_exact
            assign word = c_ROM[addr];
        end else begin : g_wide
            assign word = (addr[UADDR_W-1:c_UADDR_W] == '0) ? c_ROM[addr[c_UADDR_W-1:0]]
                                                            : c_TRAP_WORD;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/micro_sequencer.sv
// ============================================================================
// Module      : micro_sequencer
// Description : Microprogrammed main controller FSM with memory-ready wait.
//               The micro-PC is the only state; outputs decode ROM[upc].
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module micro_sequencer
    import micro_pkg::*;
#(
    parameter int                 UADDR_W   = c_UADDR_W,
    parameter logic [UADDR_W-1:0] RESET_UPC = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         Op,
    input  logic [5:0]         Funct,
    input  logic               mem_ready,
    output logic               IRWrite,
    output logic               AdrSrc,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ResultSrc,
    output logic               NextPC,
    output logic               RegW,
    output logic               MemW,
    output logic               Branch,
    output logic               ALUOp,
    output logic               mem_req,
    output logic               halted,
    output logic [UADDR_W-1:0] upc
);

    logic [UADDR_W-1:0] r_upc;
    logic [UADDR_W-1:0] w_upc_next;
    microword_t         w_word;
    logic               w_wait;
    logic               w_fire;
    logic               w_unused_funct;

    assign w_unused_funct = ^Funct[4:1];

    micro_rom #(
        .UADDR_W (UADDR_W)
    ) u_rom (
        .addr (r_upc),
        .word (w_word)
    );

    assign w_wait = w_word.memacc & ~mem_ready;
    // Pulse strobes fire only once the access completes, and never in reset.
    assign w_fire = reset & ~w_wait;

    assign IRWrite   = w_word.irwrite & w_fire;
    assign NextPC    = w_word.nextpc  & w_fire;
    assign RegW      = w_word.regw    & w_fire;
    assign Branch    = w_word.branch  & w_fire;
    assign MemW      = w_word.memw    & reset;
    assign mem_req   = w_word.memacc  & reset;
    assign halted    = (w_word.seq == SEQ_HOLD) & reset;
    assign AdrSrc    = w_word.adrsrc;
    assign ALUSrcA   = w_word.alusrca;
    assign ALUSrcB   = w_word.alusrcb;
    assign ResultSrc = w_word.resultsrc;
    assign ALUOp     = w_word.aluop;
    assign upc       = r_upc;

    always_comb begin
        w_upc_next = r_upc;
        if (!w_wait) begin
            case (w_word.seq)
                SEQ_JUMP:  w_upc_next = UADDR_W'(w_word.nxt);
                SEQ_DISP1: w_upc_next = UADDR_W'(f_disp1(Op, Funct[5]));
                SEQ_DISP2: w_upc_next = UADDR_W'(f_disp2(Funct[0]));
                default:   w_upc_next = r_upc;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_upc <= RESET_UPC;
        end else begin
            r_upc <= w_upc_next;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_micro_sequencer.sv
// ============================================================================
// Module      : tb_micro_sequencer
// Description : Randomised instruction stream against an instruction-level
//               path model, plus directed reset / wait / trap scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_micro_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       mem_ready;
    logic       IRWrite, AdrSrc, ALUSrcA, NextPC, RegW, MemW, Branch, ALUOp;
    logic       mem_req, halted;
    logic [1:0] ALUSrcB, ResultSrc;
    logic [3:0] upc;

    int n_cmp = 0;
    int n_bad = 0;

    micro_sequencer #(
        .UADDR_W   (4),
        .RESET_UPC (4'd0)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .Op        (Op),
        .Funct     (Funct),
        .mem_ready (mem_ready),
        .IRWrite   (IRWrite),
        .AdrSrc    (AdrSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ResultSrc (ResultSrc),
        .NextPC    (NextPC),
        .RegW      (RegW),
        .MemW      (MemW),
        .Branch    (Branch),
        .ALUOp     (ALUOp),
        .mem_req   (mem_req),
        .halted    (halted),
        .upc       (upc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Everything that must hold while reset is low.
    task automatic check_reset_state(input string tag);
        check({tag, ".upc"},       upc,       4'd0);
        check({tag, ".IRWrite"},   IRWrite,   1'b0);
        check({tag, ".NextPC"},    NextPC,    1'b0);
        check({tag, ".RegW"},      RegW,      1'b0);
        check({tag, ".MemW"},      MemW,      1'b0);
        check({tag, ".Branch"},    Branch,    1'b0);
        check({tag, ".mem_req"},   mem_req,   1'b0);
        check({tag, ".halted"},    halted,    1'b0);
        check({tag, ".AdrSrc"},    AdrSrc,    1'b0);
        check({tag, ".ALUSrcA"},   ALUSrcA,   1'b1);
        check({tag, ".ALUSrcB"},   ALUSrcB,   2'b10);
        check({tag, ".ResultSrc"}, ResultSrc, 2'b10);
    endtask

    // One clock cycle at microcode step 'a'; called and returns at a negedge.
    task automatic step(input logic [3:0] a, input logic rdy, input logic [1:0] op, input logic [5:0] fn);
        bit memstep;
        bit fire;
        mem_ready = rdy;
        Op        = op;
        Funct     = fn;
        #1;
        memstep = (a == 4'd0) || (a == 4'd3) || (a == 4'd5);
        fire    = !memstep || rdy;
        check("upc",     upc,     a);
        check("IRWrite", IRWrite, (a == 4'd0) && fire);
        check("NextPC",  NextPC,  (a == 4'd0) && fire);
        check("RegW",    RegW,    (a == 4'd4) || (a == 4'd8));
        check("MemW",    MemW,    a == 4'd5);
        check("Branch",  Branch,  a == 4'd9);
        check("mem_req", mem_req, memstep);
        check("halted",  halted,  a == 4'd10);
        if (a == 4'd4) check("ResultSrc_memwb", ResultSrc, 2'b01);
        @(negedge clk);
    endtask

    // Instruction-level model: the microstep path an instruction walks.
    function automatic void build_path(input logic [1:0] op, input logic [5:0] fn, output logic [3:0] p[$]);
        p = {4'd0, 4'd1};
        case (op)
            2'b00:   p = {p, (fn[5] ? 4'd7 : 4'd6), 4'd8};
            2'b01:   p = fn[0] ? {p, 4'd2, 4'd3, 4'd4} : {p, 4'd2, 4'd5};
            2'b10:   p = {p, 4'd9};
            default: p = {p, 4'd10};
        endcase
    endfunction

    task automatic run_instr(input logic [1:0] op, input logic [5:0] fn, input bit rnd);
        logic [3:0] p[$];
        logic [1:0] ro;
        logic [5:0] rf;
        bit         memstep;
        bit         disp;
        int         nst;
        build_path(op, fn, p);
        foreach (p[k]) begin
            memstep = (p[k] == 4'd0) || (p[k] == 4'd3) || (p[k] == 4'd5);
            disp    = (p[k] == 4'd1) || (p[k] == 4'd2);
            nst     = (rnd && memstep) ? int'($urandom_range(0, 2)) : 0;
            for (int s = 0; s <= nst; s++) begin
                ro = 2'($urandom_range(0, 3));
                rf = 6'($urandom);
                if (memstep) step(p[k], (s == nst), disp ? op : ro, disp ? fn : rf);
                else         step(p[k], rnd ? 1'($urandom) : 1'b1, disp ? op : ro, disp ? fn : rf);
            end
        end
    endtask

    initial begin
        logic [1:0] op;
        logic [5:0] fn;
        reset     = 1'b0;
        mem_ready = 1'b1;
        Op        = 2'b00;
        Funct     = 6'd0;
        @(negedge clk);
        #1 check_reset_state("rst");
        @(negedge clk);
        reset = 1'b1;

        run_instr(2'b00, 6'b101000, 1'b0);
        run_instr(2'b01, 6'b011001, 1'b0);
        run_instr(2'b10, 6'b000000, 1'b0);

        // Store with three wait cycles at MEMWRITE
        step(4'd0, 1'b1, 2'b00, 6'd0);
        step(4'd1, 1'b1, 2'b01, 6'b011000);
        step(4'd2, 1'b1, 2'b01, 6'b011000);
        repeat (3) step(4'd5, 1'b0, 2'b11, 6'd0);
        step(4'd5, 1'b1, 2'b11, 6'd0);

        // Fetch waits two cycles, then a register data-processing op
        repeat (2) step(4'd0, 1'b0, 2'b00, 6'd0);
        step(4'd0, 1'b1, 2'b00, 6'd0);
        step(4'd1, 1'b1, 2'b00, 6'b000100);
        step(4'd6, 1'b1, 2'b00, 6'd0);
        step(4'd8, 1'b1, 2'b00, 6'd0);

        // Trap: parks for 20 cycles regardless of inputs
        step(4'd0, 1'b1, 2'b00, 6'd0);
        step(4'd1, 1'b1, 2'b11, 6'($urandom));
        repeat (20) step(4'd10, 1'($urandom), 2'($urandom_range(0, 3)), 6'($urandom));
        reset = 1'b0;
        #1 check_reset_state("trap_rst");
        @(negedge clk);
        reset = 1'b1;

        // Reset asserted asynchronously mid-load with memory stalled
        step(4'd0, 1'b1, 2'b00, 6'd0);
        step(4'd1, 1'b1, 2'b01, 6'b011001);
        step(4'd2, 1'b1, 2'b01, 6'b011001);
        mem_ready = 1'b0;
        #1;
        check("mid.upc",     upc,     4'd3);
        check("mid.mem_req", mem_req, 1'b1);
        #2 reset = 1'b0;
        #1 check_reset_state("async_rst");
        mem_ready = 1'b1;
        @(negedge clk);
        #1 check_reset_state("async_hold");
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 80; i++) begin
            op = 2'($urandom_range(0, 2));
            fn = 6'($urandom);
            run_instr(op, fn, 1'b1);
        end
        step(4'd0, 1'b1, 2'b00, 6'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
